// File: rtl/bit_serializer_if.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// bit_serializer_if - word load handshake into bit_serializer (rev 1.0)
//============================================================================
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// bit_serializer - WIDTH-bit words to a serial bit stream, one-word hold (rev 1.0)
//============================================================================
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  wire             clock,
  input  wire             reset,
  bit_serializer_if.slave load_if,
  output logic            serial_out,
  output logic            serial_valid,
  output logic            word_done,
  output logic            busy
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  // The outgoing bit always sits at one end of shift_reg; the register moves toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit = shift_reg_q[WIDTH-1];
      assign shifted = {shift_reg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit = shift_reg_q[0];
      assign shifted = {1'b0, shift_reg_q[WIDTH-1:1]};
    end
  endgenerate

  assign load_if.load_ready = ~hold_full_q & ~reset;
  assign accept             = load_if.load_valid & load_if.load_ready;
  assign last_bit           = (bit_cnt_q == C_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_reg_q <= '0;
      hold_reg_q  <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      hold_reg_q  <= hold_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    hold_reg_d  = hold_reg_q;
    bit_cnt_d   = bit_cnt_q;
    hold_full_d = hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_reg_d = load_if.data_in;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          shift_reg_d = shifted;
          bit_cnt_d   = bit_cnt_q + C_ONE;
          if (accept) begin
            hold_reg_d  = load_if.data_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // load_ready is low while the hold is full, so no accept can collide here.
          shift_reg_d = hold_reg_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
        end else if (accept) begin
          shift_reg_d = load_if.data_in;
          bit_cnt_d   = '0;
        end else begin
          shift_reg_d = shifted;
          bit_cnt_d   = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    serial_valid = (state_q == ST_SHIFT);
    word_done    = (state_q == ST_SHIFT) & last_bit;
    busy         = (state_q == ST_SHIFT) | hold_full_q;
    serial_out   = (state_q == ST_SHIFT) ? cur_bit : IDLE_LEVEL;
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// tb_bit_serializer - vectors, corner sequences and random run vs word-level model (rev 1.0)
//============================================================================
module tb_bit_serializer;

  logic clock;
  logic reset;
  logic so_a, sv_a, wd_a, bz_a;
  logic so_b, sv_b, wd_b, bz_b;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer_if #(.WIDTH(8)) if_a ();
  bit_serializer_if #(.WIDTH(8)) if_b ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
    .clock(clock), .reset(reset), .load_if(if_a.slave),
    .serial_out(so_a), .serial_valid(sv_a), .word_done(wd_a), .busy(bz_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
    .clock(clock), .reset(reset), .load_if(if_b.slave),
    .serial_out(so_b), .serial_valid(sv_b), .word_done(wd_b), .busy(bz_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- directed vector table (DUT A: MSB first, idle 0) --------
  typedef struct {
    bit       rst;
    bit       vld;
    logic [7:0] data;
    bit       so, sv, wd, bz, lr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit vld, input logic [7:0] data,
                     input bit so, input bit sv, input bit wd, input bit bz, input bit lr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data;
    v.so = so; v.sv = sv; v.wd = wd; v.bz = bz; v.lr = lr;
    vecs.push_back(v);
  endtask

  // ---------------- word-level reference model (index 0 = A, 1 = B) ---------
  logic [7:0] m_word   [2];
  int         m_left   [2];
  logic [7:0] m_held   [2];
  bit         m_held_v [2];
  bit         m_msb    [2] = '{1'b1, 1'b0};
  bit         m_idle   [2] = '{1'b0, 1'b1};

  task automatic model_check(input int i, input logic so, input logic sv,
                             input logic wd, input logic bz, input logic lr);
    int  pos;
    bit  e_so;
    pos  = 8 - m_left[i];
    if (m_left[i] > 0) e_so = m_msb[i] ? m_word[i][7 - pos] : m_word[i][pos];
    else               e_so = m_idle[i];
    check($sformatf("rnd%0d serial_out", i),   so, e_so);
    check($sformatf("rnd%0d serial_valid", i), sv, m_left[i] > 0);
    check($sformatf("rnd%0d word_done", i),    wd, m_left[i] == 1);
    check($sformatf("rnd%0d busy", i),         bz, (m_left[i] > 0) || m_held_v[i]);
    check($sformatf("rnd%0d load_ready", i),   lr, !m_held_v[i] && !reset);
  endtask

  task automatic model_step(input int i, input logic vld, input logic [7:0] d);
    bit acc;
    acc = vld && !m_held_v[i] && !reset;
    if (reset) begin
      m_left[i] = 0; m_held_v[i] = 1'b0;
    end else begin
      if (m_left[i] > 0) m_left[i]--;
      if (m_left[i] == 0) begin
        if (m_held_v[i]) begin
          m_word[i] = m_held[i]; m_left[i] = 8; m_held_v[i] = 1'b0;
        end else if (acc) begin
          m_word[i] = d; m_left[i] = 8;
        end
      end else if (acc) begin
        m_held[i] = d; m_held_v[i] = 1'b1;
      end
    end
  endtask

  logic [7:0] lsb_exp;

  initial begin
    reset = 1'b1;
    if_a.load_valid = 1'b0; if_a.data_in = '0;
    if_b.load_valid = 1'b0; if_b.data_in = '0;

    //   rst vld data   so sv wd bz lr
    add(1, 0, 8'h00,  0, 0, 0, 0, 0);
    // single word A5
    add(0, 1, 8'hA5,  0, 0, 0, 0, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 1, 1, 1);
    add(0, 0, 8'h00,  0, 0, 0, 0, 1);
    // back-to-back A5 then 3C via hold; junk offered while hold is full
    add(0, 1, 8'hA5,  0, 0, 0, 0, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 1, 8'h3C,  0, 1, 0, 1, 1);
    add(0, 1, 8'h99,  1, 1, 0, 1, 0);
    add(0, 1, 8'h99,  0, 1, 0, 1, 0);
    add(0, 1, 8'h99,  0, 1, 0, 1, 0);
    add(0, 1, 8'h99,  1, 1, 0, 1, 0);
    add(0, 1, 8'h99,  0, 1, 0, 1, 0);
    add(0, 1, 8'h99,  1, 1, 1, 1, 0);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 1, 1, 1);
    add(0, 0, 8'h00,  0, 0, 0, 0, 1);
    // last-bit bypass FF then 00; load_ready stays high throughout
    add(0, 1, 8'hFF,  0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) add(0, 0, 8'h00, 1, 1, 0, 1, 1);
    add(0, 1, 8'h00,  1, 1, 1, 1, 1);
    for (int k = 0; k < 7; k++) add(0, 0, 8'h00, 0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 1, 1, 1);
    add(0, 0, 8'h00,  0, 0, 0, 0, 1);
    // reset while AA shifts and FF is held; neither may reappear
    add(0, 1, 8'hAA,  0, 0, 0, 0, 1);
    add(0, 1, 8'hFF,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 0);
    add(0, 0, 8'h00,  1, 1, 0, 1, 0);
    add(1, 1, 8'h55,  0, 1, 0, 1, 0);
    add(0, 0, 8'h00,  0, 0, 0, 0, 1);
    add(0, 1, 8'hC3,  0, 0, 0, 0, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  0, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 0, 1, 1);
    add(0, 0, 8'h00,  1, 1, 1, 1, 1);
    add(0, 0, 8'h00,  0, 0, 0, 0, 1);

    repeat (3) @(posedge clock);

    foreach (vecs[k]) begin
      @(posedge clock); #1;
      reset           = vecs[k].rst;
      if_a.load_valid = vecs[k].vld;
      if_a.data_in    = vecs[k].data;
      @(negedge clock);
      check($sformatf("vec%0d serial_out", k),   so_a,            vecs[k].so);
      check($sformatf("vec%0d serial_valid", k), sv_a,            vecs[k].sv);
      check($sformatf("vec%0d word_done", k),    wd_a,            vecs[k].wd);
      check($sformatf("vec%0d busy", k),         bz_a,            vecs[k].bz);
      check($sformatf("vec%0d load_ready", k),   if_a.load_ready, vecs[k].lr);
    end

    // LSB-first with idle level 1 on DUT B: word 01 -> 1 then seven 0s, then line at 1
    @(posedge clock); #1;
    if_a.load_valid = 1'b0;
    if_b.load_valid = 1'b1; if_b.data_in = 8'h01;
    @(negedge clock);
    check("lsb idle serial_out", so_b, 1'b1);
    check("lsb idle load_ready", if_b.load_ready, 1'b1);
    lsb_exp = 8'b0000_0001;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if_b.load_valid = 1'b0;
      @(negedge clock);
      check($sformatf("lsb bit%0d serial_out", k), so_b, lsb_exp[k]);
      check($sformatf("lsb bit%0d serial_valid", k), sv_b, 1'b1);
      check($sformatf("lsb bit%0d word_done", k), wd_b, k == 7);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("lsb after serial_out", so_b, 1'b1);
      check("lsb after serial_valid", sv_b, 1'b0);
      check("lsb after busy", bz_b, 1'b0);
    end

    // randomized run on both configurations against the word-level model
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_held_v[i] = 1'b0; m_word[i] = '0; m_held[i] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      reset           = (cyc == 0) || ($urandom_range(0, 149) == 0);
      if_a.load_valid = ($urandom_range(0, 3) != 0);
      if_a.data_in    = 8'($urandom);
      if_b.load_valid = ($urandom_range(0, 2) == 0);
      if_b.data_in    = 8'($urandom);
      @(negedge clock);
      model_check(0, so_a, sv_a, wd_a, bz_a, if_a.load_ready);
      model_check(1, so_b, sv_b, wd_b, bz_b, if_b.load_ready);
      model_step(0, if_a.load_valid, if_a.data_in);
      model_step(1, if_b.load_valid, if_b.data_in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
